// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, master FSM states and the
// saturating helper used by the ack timeout counter.
package wb_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int WB_DAT_W  = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WBM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  function automatic logic [WBM_CNT_W-1:0] sat_inc(input logic [WBM_CNT_W-1:0] v);
    logic [WBM_CNT_W-1:0] r;
    if (v == {WBM_CNT_W{1'b1}}) r = v;
    else                        r = v + WBM_CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master: one command in, one bus cycle,
// one response out, with a per-transaction ack timeout.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i
);

  localparam logic [WBM_CNT_W:0] TO_LIM = (WBM_CNT_W+1)'(TIMEOUT_CYCLES);

  wbm_state_t            state_q, state_d;
  logic [WBM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_hit;

  // cnt_q counts completed ack-less BUS cycles, so the cycle that brings it
  // to the limit is the last one cyc/stb stay high.
  always_comb begin
    timeout_hit = (TO_LIM != '0) &&
                  (({1'b0, cnt_q} + (WBM_CNT_W+1)'(1)) >= TO_LIM);
  end

  assign cmd_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout firing in the same cycle.
        if (wb_ack_i) begin
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout_hit) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized
// transactions against a transaction-level expectation model.
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Command presented while a response is held (to prove it is not taken early)
  logic        hold_we;
  logic [31:0] hold_adr, hold_dat;
  logic [3:0]  hold_sel;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] adr);
    return adr ^ 32'hC3A5_5A3C;
  endfunction

  // One full transaction; called and returns at a negedge. The slave acks in
  // stb cycle ack_dly+1 (never if ack_dly >= TO); the response is held rsp_dly cycles.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] rd_word,
                        input int ack_dly, input int rsp_dly, input logic hold_cmd);
    int          stb_cnt;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err = (ack_dly >= TO);
    exp_stb = exp_err ? TO : ack_dly + 1;
    exp_dat = (exp_err || we) ? 32'd0 : rd_word;

    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;

    stb_cnt = 0;
    while (wb_cyc_o && stb_cnt < 64) begin
      stb_cnt++;
      check("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
      check("bus_adr", wb_adr_o, adr);
      check("bus_dat", wb_dat_o, dat);
      check("bus_sel", 32'(wb_sel_o), 32'(sel));
      check("bus_we", 32'(wb_we_o), 32'(we));
      check("no_rsp_in_bus", 32'(rsp_valid), 32'd0);
      check("cmd_ready_bus", 32'(cmd_ready), 32'd0);
      if (stb_cnt == ack_dly + 1) begin
        wb_ack_i = 1'b1; wb_dat_i = rd_word;
      end else begin
        wb_ack_i = 1'b0; wb_dat_i = $urandom;
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0;
    check("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));

    rsp_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      if (hold_cmd) begin
        cmd_valid = 1'b1; cmd_we = hold_we; cmd_adr = hold_adr;
        cmd_dat = hold_dat; cmd_sel = hold_sel;
      end
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
      @(negedge clk);
      check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      check("rsp_hold_dat", rsp_dat, exp_dat);
      check("rsp_hold_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_hold_rdy", 32'(cmd_ready), 32'd0);
      check("rsp_hold_cyc", 32'(wb_cyc_o), 32'd0);
    end
    wb_ack_i  = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    check("cyc_after_rsp", 32'(wb_cyc_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        r_we;
    logic [31:0] r_adr;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_dat = 32'd0;
    cmd_sel = 4'd0; rsp_ready = 1'b0; wb_dat_i = 32'd0; wb_ack_i = 1'b0;
    hold_we = 1'b0; hold_adr = 32'd0; hold_dat = 32'd0; hold_sel = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    reset = 1'b0;
    #1 check("post_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Write acked in third stb cycle
    do_txn(1'b1, 32'h2000_0004, 32'h0000_00A5, 4'hF, 32'hFFFF_FFFF, 2, 0, 1'b0);
    // Read with immediate ack
    do_txn(1'b0, 32'h3000_0000, 32'h1111_1111, 4'hF, 32'hDEAD_BEEF, 0, 1, 1'b0);
    // Timeout, then a normal command
    do_txn(1'b0, 32'h5000_0000, 32'h0, 4'h3, 32'h7777_7777, 20, 0, 1'b0);
    do_txn(1'b0, 32'h5000_0004, 32'h0, 4'hF, 32'h0BAD_F00D, 1, 0, 1'b0);
    // Ack on the exact timeout cycle
    do_txn(1'b0, 32'h6000_0008, 32'h0, 4'hF, 32'h1234_5678, TO - 1, 0, 1'b0);
    // Long response stall with the next command waiting
    hold_we = 1'b1; hold_adr = 32'h4000_0010; hold_dat = 32'hCAFE_0001; hold_sel = 4'h5;
    do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'hA5A5_0000, 0, 10, 1'b1);
    do_txn(hold_we, hold_adr, hold_dat, hold_sel, 32'h0, 0, 0, 1'b0);

    // Reset in second BUS cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h7000_0000; cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rstbus_cyc1", 32'(wb_cyc_o), 32'd1);
    @(negedge clk);
    check("rstbus_cyc2", 32'(wb_cyc_o), 32'd1);
    reset = 1'b1;
    #1 check("rstbus_rdy_in_rst", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("rstbus_cyc_drop", 32'(wb_cyc_o), 32'd0);
    check("rstbus_stb_drop", 32'(wb_stb_o), 32'd0);
    check("rstbus_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1 check("rstbus_rdy", 32'(cmd_ready), 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_rsp", 32'(rsp_valid), 32'd0);
      check("stray_ack_cyc", 32'(wb_cyc_o), 32'd0);
    end
    wb_ack_i = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_adr = $urandom;
      do_txn(r_we, r_adr, $urandom, 4'($urandom_range(0, 15)), slave_word(r_adr),
             $urandom_range(0, TO + 2), $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
